clk_5phase_supervisor: RTL and testbench
========================================

CLK_5PHASE_SUPERVISOR -- requirements
Module: clk_5phase_supervisor

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 16: PLL reset pulse length in clk_in cycles.
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 1024: maximum cycles to wait for lock.
REQ-003 SHALL have parameter STABLE_CYCLES, default 64: consecutive locked cycles required before release.
REQ-004 SHALL have parameter STAGGER, default 4: cycles between successive phase-reset releases.
REQ-005 SHALL have parameter MAX_RETRY, default 3: failed lock attempts tolerated before FAULT.
REQ-006 SHALL have port clk_in, input, 1: single clock; reset is asynchronous and active-low.
REQ-007 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-008 SHALL have port pll_locked, input, 1: PLL lock flag, asynchronous to clk_in.
REQ-009 SHALL have port restart, input, 1: single-cycle request to restart the sequence.
REQ-010 SHALL have port pll_areset, output, 1: active-high reset to the 5-phase PLL.
REQ-011 SHALL have port phase_rst_n, output, 5: active-low resets for the logic on phases 0/72/144/216/288 (bit k = clk k).
REQ-012 SHALL have port ready, output, 1: all phase domains released and PLL locked.
REQ-013 SHALL have port fault, output, 1: retry budget exhausted.
REQ-014 SHALL have port state, output, 3: current FSM state.
REQ-015 SHALL have port retry_cnt, output, 2: failed attempts in the current sequence.

Function
REQ-016 SHALL synchronise pll_locked through two flops into locked_s; all decisions use locked_s only.
REQ-017 SHALL implement FSM encodings PLL_RST=0, WAIT_LOCK=1, STABLE=2, RELEASE=3, RUN=4, FAULT=5.
REQ-018 PLL_RST SHALL hold pll_areset=1 for exactly RST_CYCLES cycles, then go to WAIT_LOCK.
REQ-019 WAIT_LOCK: on locked_s=1, go to STABLE; on LOCK_TIMEOUT cycles with no lock, count a failure (REQ-024).
REQ-020 STABLE: after STABLE_CYCLES consecutive locked_s=1, go to RELEASE; on locked_s=0, return to WAIT_LOCK with both counters cleared and no failure counted.
REQ-021 RELEASE: phase_rst_n[k] SHALL go high STAGGER*k cycles after RELEASE entry (bit 0 on the entry cycle); bits already released stay high.
REQ-022 SHALL enter RUN one cycle after bit 4 is released, then assert ready=1 and clear retry_cnt.
REQ-023 Loss of lock (locked_s=0) in RELEASE or RUN SHALL, at the next edge, drive phase_rst_n=5'b00000 and ready=0, and count a failure.
REQ-024 A failure SHALL increment retry_cnt and go to PLL_RST; if retry_cnt already equals MAX_RETRY, it SHALL go to FAULT instead, leaving retry_cnt unchanged.
REQ-025 FAULT SHALL hold fault=1, pll_areset=1 and phase_rst_n=0 until restart.
REQ-026 restart=1 in any state SHALL clear retry_cnt and all counters and go to PLL_RST at the next edge; restart takes priority over every other transition.
REQ-027 pll_areset SHALL be 1 only in PLL_RST and FAULT; phase_rst_n SHALL be 0 in every state except RELEASE (partial) and RUN (all ones).
REQ-028 All outputs SHALL be registered.

Reset
REQ-029 reset_n=0 SHALL asynchronously force state=PLL_RST, pll_areset=1, phase_rst_n=0, ready=0, fault=0, retry_cnt=0, all counters=0 and both sync flops=0.
REQ-030 After reset_n deasserts, the PLL_RST count SHALL start on the first clk_in edge.

Configuration
REQ-031 Macro CLK5_LOSS_COUNT_EN defined: the module SHALL add an output lock_loss_cnt[7:0] that counts REQ-023 events, saturates at 255 and is cleared only by reset_n.
REQ-032 Macro CLK5_LOSS_COUNT_EN undefined: the port and its logic SHALL be absent, with all other behaviour identical.

Verification
REQ-033 Defaults; pll_locked=1 from time 0 -> pll_areset high 16 cycles; phase_rst_n bits release at 4-cycle spacing; ready=1; retry_cnt=0.
REQ-034 pll_locked held 0 -> three timeouts of 1024 cycles with retry_cnt 1,2,3; fourth timeout -> FAULT, fault=1, pll_areset=1.
REQ-035 In RUN, pll_locked=0 for 1 cycle -> phase_rst_n=0 and ready=0 within 3 cycles; state=PLL_RST; retry_cnt=1; with CLK5_LOSS_COUNT_EN, lock_loss_cnt=1.
REQ-036 In STABLE, locked glitch low at cycle 30 -> WAIT_LOCK, retry_cnt unchanged, full 64 cycles required again.
REQ-037 In FAULT, restart pulse -> PLL_RST next edge, fault=0, retry_cnt=0; mid-RELEASE restart -> all phase_rst_n=0 next edge.
REQ-038 reset_n pulsed low mid-RUN -> all outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/clk_5phase_supervisor.sv
// Reset/lock supervisor for a 5-phase PLL: pulses the PLL reset, qualifies lock, then
// releases the five phase-domain resets in a staggered order. Optional macro CLK5_LOSS_COUNT_EN adds lock_loss_cnt.
module clk_5phase_supervisor #(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 1024,
    parameter int unsigned STABLE_CYCLES = 64,
    parameter int unsigned STAGGER       = 4,
    parameter int unsigned MAX_RETRY     = 3
) (
    input  logic       clk_in,
    input  logic       reset_n,
    input  logic       pll_locked,
    input  logic       restart,
    output logic       pll_areset,
    output logic [4:0] phase_rst_n,
    output logic       ready,
    output logic       fault,
    output logic [2:0] state,
    output logic [1:0] retry_cnt
`ifdef CLK5_LOSS_COUNT_EN
    ,
    output logic [7:0] lock_loss_cnt
`endif
);

    localparam int unsigned REL_SPAN  = 4 * STAGGER;
    localparam int unsigned CNT_MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int unsigned CNT_MAX_B = (STABLE_CYCLES > REL_SPAN) ? STABLE_CYCLES : REL_SPAN;
    localparam int unsigned CNT_MAX   = (CNT_MAX_A > CNT_MAX_B) ? CNT_MAX_A : CNT_MAX_B;
    localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_PLL_RST   = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RELEASE   = 3'd3,
        S_RUN       = 3'd4,
        S_FAULT     = 3'd5
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [1:0]         r_retry;
    logic [1:0]         w_retry_nxt;
    logic               w_fail;

    logic               r_sync1;
    logic               r_sync2;
    logic               w_locked_s;

    logic               r_pll_areset;
    logic [4:0]         r_phase_rst_n;
    logic               r_ready;
    logic               r_fault;
    logic               w_areset_nxt;
    logic [4:0]         w_phase_nxt;
    logic               w_ready_nxt;
    logic               w_fault_nxt;

    // Two-flop synchroniser for the asynchronous lock flag
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= pll_locked;
            r_sync2 <= r_sync1;
        end
    end

    assign w_locked_s = r_sync2;

    // State register with its phase counter and retry count
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_PLL_RST;
            r_cnt   <= '0;
            r_retry <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_retry <= w_retry_nxt;
        end
    end

    // Next-state logic; restart overrides everything, failures funnel through one path
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_retry_nxt = r_retry;
        w_fail      = 1'b0;

        if (restart) begin
            w_state_nxt = S_PLL_RST;
            w_cnt_nxt   = '0;
            w_retry_nxt = '0;
        end else begin
            case (r_state)
                S_PLL_RST: begin
                    if (r_cnt == CNT_W'(RST_CYCLES - 1)) begin
                        w_state_nxt = S_WAIT_LOCK;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                S_WAIT_LOCK: begin
                    if (w_locked_s) begin
                        w_state_nxt = S_STABLE;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
                        w_fail = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                S_STABLE: begin
                    if (!w_locked_s) begin
                        w_state_nxt = S_WAIT_LOCK;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == CNT_W'(STABLE_CYCLES - 1)) begin
                        w_state_nxt = S_RELEASE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                S_RELEASE: begin
                    if (!w_locked_s) begin
                        w_fail = 1'b1;
                    end else if (r_cnt == CNT_W'(REL_SPAN)) begin
                        w_state_nxt = S_RUN;
                        w_cnt_nxt   = '0;
                        w_retry_nxt = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                S_RUN: begin
                    if (!w_locked_s) begin
                        w_fail = 1'b1;
                    end
                end
                S_FAULT: begin
                    w_state_nxt = S_FAULT;
                end
                default: begin
                    w_state_nxt = S_PLL_RST;
                    w_cnt_nxt   = '0;
                end
            endcase

            if (w_fail) begin
                w_cnt_nxt = '0;
                if (r_retry == 2'(MAX_RETRY)) begin
                    w_state_nxt = S_FAULT;
                end else begin
                    w_state_nxt = S_PLL_RST;
                    w_retry_nxt = r_retry + 2'd1;
                end
            end
        end
    end

    // Output decode from the upcoming state so the registered outputs track the state register
    always_comb begin
        w_areset_nxt = 1'b0;
        w_phase_nxt  = '0;
        w_ready_nxt  = 1'b0;
        w_fault_nxt  = 1'b0;
        case (w_state_nxt)
            S_PLL_RST: begin
                w_areset_nxt = 1'b1;
            end
            S_RELEASE: begin
                for (int k = 0; k < 5; k++) begin
                    w_phase_nxt[k] = (w_cnt_nxt >= CNT_W'(STAGGER * unsigned'(k)));
                end
            end
            S_RUN: begin
                w_phase_nxt = '1;
                w_ready_nxt = 1'b1;
            end
            S_FAULT: begin
                w_areset_nxt = 1'b1;
                w_fault_nxt  = 1'b1;
            end
            default: begin
                w_areset_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            r_pll_areset  <= 1'b1;
            r_phase_rst_n <= '0;
            r_ready       <= 1'b0;
            r_fault       <= 1'b0;
        end else begin
            r_pll_areset  <= w_areset_nxt;
            r_phase_rst_n <= w_phase_nxt;
            r_ready       <= w_ready_nxt;
            r_fault       <= w_fault_nxt;
        end
    end

    assign pll_areset  = r_pll_areset;
    assign phase_rst_n = r_phase_rst_n;
    assign ready       = r_ready;
    assign fault       = r_fault;
    assign state       = r_state;
    assign retry_cnt   = r_retry;

`ifdef CLK5_LOSS_COUNT_EN
    logic       w_loss_evt;
    logic [7:0] r_loss_cnt;

    // Lock lost while phase domains are (partly) released; only reset_n clears the tally
    assign w_loss_evt = !restart && !w_locked_s &&
                        ((r_state == S_RELEASE) || (r_state == S_RUN));

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            r_loss_cnt <= '0;
        end else if (w_loss_evt && (r_loss_cnt != 8'hFF)) begin
            r_loss_cnt <= r_loss_cnt + 8'd1;
        end
    end

    assign lock_loss_cnt = r_loss_cnt;
`endif

endmodule

// File: tb/tb_clk_5phase_supervisor.sv
// Bench for clk_5phase_supervisor: directed scenarios plus random lock dropouts,
// checked every cycle against a cycle-level model of the sequencing rules.
module tb_clk_5phase_supervisor;

    localparam int unsigned RST_CYCLES    = 16;
    localparam int unsigned LOCK_TIMEOUT  = 1024;
    localparam int unsigned STABLE_CYCLES = 64;
    localparam int unsigned STAGGER       = 4;
    localparam int unsigned MAX_RETRY     = 3;

    logic       clk_in = 1'b0;
    logic       reset_n;
    logic       pll_locked;
    logic       restart;
    logic       pll_areset;
    logic [4:0] phase_rst_n;
    logic       ready;
    logic       fault;
    logic [2:0] state;
    logic [1:0] retry_cnt;
`ifdef CLK5_LOSS_COUNT_EN
    logic [7:0] lock_loss_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;
    string step_tag = "init";

    // Model: state number, edges spent in the state, retries, loss events, lock history
    int   m_st, m_t, m_retry, m_loss;
    logic m_s1, m_s2;

    always #5 clk_in = ~clk_in;

    clk_5phase_supervisor dut (
        .clk_in      (clk_in),
        .reset_n     (reset_n),
        .pll_locked  (pll_locked),
        .restart     (restart),
        .pll_areset  (pll_areset),
        .phase_rst_n (phase_rst_n),
        .ready       (ready),
        .fault       (fault),
        .state       (state),
        .retry_cnt   (retry_cnt)
`ifdef CLK5_LOSS_COUNT_EN
        ,
        .lock_loss_cnt (lock_loss_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s (cycle %0d): observed 0x%0h expected 0x%0h", tag, cycle, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_t = 0; m_retry = 0; m_loss = 0; m_s1 = 1'b0; m_s2 = 1'b0;
    endtask

    task automatic model_fail();
        m_t = 0;
        if (m_retry == int'(MAX_RETRY)) m_st = 5;
        else begin
            m_retry++;
            m_st = 0;
        end
    endtask

    // One clock edge of the sequencing rules, using the lock level seen two edges ago
    task automatic model_edge(input logic lk, input logic rs);
        logic ls;
        ls   = m_s2;
        m_s2 = m_s1;
        m_s1 = lk;
        if (rs) begin
            m_st = 0; m_t = 0; m_retry = 0;
        end else begin
            case (m_st)
                0: begin
                    m_t++;
                    if (m_t == int'(RST_CYCLES)) begin m_st = 1; m_t = 0; end
                end
                1: begin
                    if (ls) begin m_st = 2; m_t = 0; end
                    else begin
                        m_t++;
                        if (m_t == int'(LOCK_TIMEOUT)) model_fail();
                    end
                end
                2: begin
                    if (!ls) begin m_st = 1; m_t = 0; end
                    else begin
                        m_t++;
                        if (m_t == int'(STABLE_CYCLES)) begin m_st = 3; m_t = 0; end
                    end
                end
                3: begin
                    if (!ls) begin
                        if (m_loss < 255) m_loss++;
                        model_fail();
                    end else if (m_t == 4 * int'(STAGGER)) begin
                        m_st = 4; m_t = 0; m_retry = 0;
                    end else m_t++;
                end
                4: begin
                    if (!ls) begin
                        if (m_loss < 255) m_loss++;
                        model_fail();
                    end
                end
                default: m_st = 5;
            endcase
        end
    endtask

    function automatic logic [12:0] exp_vec();
        logic [4:0] ph;
        ph = '0;
        if (m_st == 4) ph = '1;
        else if (m_st == 3) begin
            for (int k = 0; k < 5; k++) if (m_t >= int'(STAGGER) * k) ph[k] = 1'b1;
        end
        return {3'(m_st), (m_st == 0 || m_st == 5), ph, (m_st == 4), (m_st == 5), 2'(m_retry)};
    endfunction

    // Drive one cycle of inputs, advance the model on the same edge, compare just after it
    task automatic cyc(input logic lk, input logic rs);
        pll_locked = lk;
        restart    = rs;
        @(posedge clk_in);
        model_edge(lk, rs);
        cycle++;
        #1;
        check(step_tag, {19'd0, state, pll_areset, phase_rst_n, ready, fault, retry_cnt}, 32'(exp_vec()));
`ifdef CLK5_LOSS_COUNT_EN
        check({step_tag, "_loss"}, 32'(lock_loss_cnt), 32'(m_loss));
`endif
    endtask

    task automatic run_to(input int st, input int t, input int budget, input string tag);
        int n;
        n = 0;
        while (!(m_st == st && m_t == t) && n < budget) begin
            cyc(1'b1, 1'b0);
            n++;
        end
        check({tag, "_reached"}, 32'(m_st == st && m_t == t), 32'd1);
    endtask

    initial begin
        int rise[5];
        int areset_low_at;
        int run_len, n_to, wl_len, drop, lg_phase0;
        logic saw_wait;
        logic lk, rs;

        reset_n = 1'b0; pll_locked = 1'b1; restart = 1'b0;
        model_reset();
        #12;
        check("reset_vals", {19'd0, state, pll_areset, phase_rst_n, ready, fault, retry_cnt},
              {19'd0, 3'd0, 1'b1, 5'd0, 1'b0, 1'b0, 2'd0});
        @(negedge clk_in);
        reset_n = 1'b1;

        // Boot with a steady lock
        step_tag = "boot";
        for (int k = 0; k < 5; k++) rise[k] = -1;
        areset_low_at = -1;
        for (int i = 0; i < 110; i++) begin
            cyc(1'b1, 1'b0);
            if (!pll_areset && areset_low_at < 0) areset_low_at = i + 1;
            for (int k = 0; k < 5; k++) if (phase_rst_n[k] && rise[k] < 0) rise[k] = i;
        end
        check("areset_edges", 32'(areset_low_at), RST_CYCLES);
        for (int k = 1; k < 5; k++) check("stagger", 32'(rise[k] - rise[k-1]), STAGGER);
        check("boot_ready", 32'(ready), 32'd1);
        check("boot_retry", 32'(retry_cnt), 32'd0);

        // One-cycle lock drop while running
        step_tag = "run_drop";
        lg_phase0 = -1;
        cyc(1'b0, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            cyc(1'b1, 1'b0);
            if (phase_rst_n == 5'd0 && !ready && lg_phase0 < 0) lg_phase0 = i;
        end
        check("drop_latency_ok", 32'(lg_phase0 >= 1 && lg_phase0 <= 3), 32'd1);
        check("drop_state", 32'(state), 32'd0);
        check("drop_retry", 32'(retry_cnt), 32'd1);
`ifdef CLK5_LOSS_COUNT_EN
        check("drop_loss_cnt", 32'(lock_loss_cnt), 32'd1);
`endif
        step_tag = "relock";
        for (int i = 0; i < 110; i++) cyc(1'b1, 1'b0);
        check("relock_retry", 32'(retry_cnt), 32'd0);

        // Glitch during the stability window restarts the window
        step_tag = "stable_glitch";
        cyc(1'b1, 1'b1);
        run_to(2, 30, 200, "stable30");
        cyc(1'b0, 1'b0);
        run_len = 0; saw_wait = 1'b0;
        for (int i = 0; i < 300 && state != 3'd3; i++) begin
            cyc(1'b1, 1'b0);
            if (state == 3'd1) begin saw_wait = 1'b1; run_len = 0; end
            else if (state == 3'd2) run_len++;
        end
        check("glitch_wait", 32'(saw_wait), 32'd1);
        check("glitch_retry", 32'(retry_cnt), 32'd0);
        check("glitch_window", 32'(run_len), STABLE_CYCLES);
        for (int i = 0; i < 30; i++) cyc(1'b1, 1'b0);

        // No lock at all: three retries, then fault
        step_tag = "no_lock";
        cyc(1'b0, 1'b1);
        n_to = 0; wl_len = 0;
        for (int i = 0; i < 5000 && state != 3'd5; i++) begin
            cyc(1'b0, 1'b0);
            if (state == 3'd1) wl_len++;
            else if (wl_len > 0) begin
                check("timeout_len", 32'(wl_len), LOCK_TIMEOUT);
                if (state == 3'd0) check("timeout_retry", 32'(retry_cnt), 32'(n_to + 1));
                n_to++;
                wl_len = 0;
            end
        end
        check("timeout_count", 32'(n_to), 32'd4);
        check("fault_flag", {30'd0, fault, pll_areset}, 32'd3);
        check("fault_retry", 32'(retry_cnt), 32'd3);
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0);

        step_tag = "fault_restart";
        cyc(1'b1, 1'b1);
        check("restart_fault", {29'd0, fault, retry_cnt}, 32'd0);

        // Restart in the middle of the staggered release
        step_tag = "release_restart";
        run_to(3, 8, 300, "release8");
        check("release_partial", 32'(phase_rst_n), 32'h07);
        cyc(1'b1, 1'b1);
        check("release_restart_phase", 32'(phase_rst_n), 32'd0);

        // Random lock dropouts and sporadic restarts
        step_tag = "random";
        drop = 0;
        for (int i = 0; i < 6000; i++) begin
            if (drop == 0) begin
                if ($urandom_range(0, 299) == 0) drop = int'($urandom_range(1, 40));
                else if ($urandom_range(0, 1999) == 0) drop = int'($urandom_range(900, 2200));
            end
            lk = (drop == 0);
            if (drop > 0) drop--;
            rs = ($urandom_range(0, 999) == 0);
            cyc(lk, rs);
        end

        // Asynchronous reset while running
        step_tag = "async_rst";
        cyc(1'b1, 1'b1);
        run_to(4, 0, 300, "run_again");
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_vals", {19'd0, state, pll_areset, phase_rst_n, ready, fault, retry_cnt},
              {19'd0, 3'd0, 1'b1, 5'd0, 1'b0, 1'b0, 2'd0});
`ifdef CLK5_LOSS_COUNT_EN
        check("async_reset_loss", 32'(lock_loss_cnt), 32'd0);
`endif
        model_reset();
        @(negedge clk_in);
        reset_n = 1'b1;
        step_tag = "post_reset";
        for (int i = 0; i < 110; i++) cyc(1'b1, 1'b0);
        check("post_reset_ready", 32'(ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
